// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-code consumers: lock FSM states,
// per-sample classification and output widths.
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT,
    ACQ,
    LOCKED
  } lock_state_e;

  typedef enum logic [2:0] {
    NONE,
    HOLD,
    GOOD,
    SEQ,
    ILL
  } sample_cls_e;

  localparam int ERR_CNT_W = 8;

  function automatic int phase_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson-word checker: flags legal thermometer codes and
// decodes them to a phase index 0..2N-1.
import johnson_pkg::*;

module johnson_code_check #(
  parameter int N = 4,
  localparam int PW = phase_width(N)
) (
  input  logic [N-1:0]  q_in,
  output logic          legal,
  output logic [PW-1:0] phase
);

  logic [PW:0] ones;
  logic [PW:0] edges;

  // A legal Johnson word has at most one 0/1 boundary; the ones count
  // then pins the position along the ring.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + (PW+1)'(q_in[i]);
    end
    for (int i = 0; i < N - 1; i++) begin
      edges = edges + (PW+1)'(q_in[i] ^ q_in[i+1]);
    end
    legal = (edges <= (PW+1)'(1));
    if (q_in[0]) begin
      phase = PW'((PW+1)'(2 * N) - ones);
    end else begin
      phase = PW'(ones);
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder with successor checking and lock FSM.
// Optional sticky error flag and clear input: JOHNSON_DEC_STICKY_ERR_EN.
import johnson_pkg::*;

module johnson_phase_decoder #(
  parameter int N          = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_LIMIT  = 2,
  localparam int PW = phase_width(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         q_in,
  input  logic                 in_valid,
  output logic [PW-1:0]        phase,
  output logic                 phase_valid,
  output logic                 locked,
  output logic                 illegal,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef JOHNSON_DEC_STICKY_ERR_EN
  ,
  input  logic                 err_clr,
  output logic                 err_sticky
`endif
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(2 * N - 1);

  lock_state_e          state_q, state_d;
  sample_cls_e          cls;
  logic [PW-1:0]        phase_q, phase_d, next_phase;
  logic                 phase_valid_q, phase_valid_d;
  logic                 illegal_q, illegal_d;
  logic                 seq_err_q, seq_err_d;
  logic [GW-1:0]        good_q, good_d;
  logic [BW-1:0]        bad_q, bad_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 code_legal;
  logic [PW-1:0]        code_phase;
  logic                 is_err;
  logic                 err_clr_i;

  johnson_code_check #(.N(N)) u_check (
    .q_in  (q_in),
    .legal (code_legal),
    .phase (code_phase)
  );

`ifdef JOHNSON_DEC_STICKY_ERR_EN
  logic err_sticky_q, err_sticky_d;
  assign err_clr_i    = err_clr;
  assign err_sticky_d = is_err | (err_sticky_q & ~err_clr);
  assign err_sticky   = err_sticky_q;
`else
  assign err_clr_i = 1'b0;
`endif

  assign next_phase = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;

  // phase_q doubles as the stored previous phase; it is only meaningful
  // outside HUNT, so a legal word in HUNT just anchors (classed as HOLD).
  always_comb begin
    cls = NONE;
    if (in_valid) begin
      if (!code_legal) begin
        cls = ILL;
      end else if (state_q == HUNT || code_phase == phase_q) begin
        cls = HOLD;
      end else if (code_phase == next_phase) begin
        cls = GOOD;
      end else begin
        cls = SEQ;
      end
    end
  end

  assign is_err = (cls == SEQ) || (cls == ILL);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    case (state_q)
      HUNT: begin
        if (cls == HOLD) begin
          state_d = ACQ;
          good_d  = '0;
          bad_d   = '0;
        end
      end
      ACQ: begin
        if (cls == GOOD) begin
          if (good_q + 1'b1 == GW'(LOCK_COUNT)) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end else if (is_err) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (cls == GOOD) begin
          bad_d = '0;
        end else if (is_err) begin
          if (bad_q + 1'b1 == BW'(ERR_LIMIT)) begin
            state_d = HUNT;
            bad_d   = '0;
            good_d  = '0;
          end else begin
            bad_d = bad_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    illegal_d     = (cls == ILL);
    seq_err_d     = (cls == SEQ);
    err_count_d   = err_count_q;
    if (in_valid && code_legal) begin
      phase_d       = code_phase;
      phase_valid_d = 1'b1;
    end
    // A clear and an error in the same cycle leave the new error counted.
    if (err_clr_i) begin
      err_count_d = '0;
    end
    if (is_err && err_count_d != '1) begin
      err_count_d = err_count_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      good_q        <= '0;
      bad_q         <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      illegal_q     <= illegal_d;
      seq_err_q     <= seq_err_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      err_count_q   <= err_count_d;
    end
  end

`ifdef JOHNSON_DEC_STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end
`endif

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = (state_q == LOCKED);
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the pipelined Johnson counter. Samples its N-bit Johnson word each valid cycle.
- Checks the code is a legal Johnson state and decodes it to a binary phase index 0..2N-1.
- Verifies each new value is the expected successor and runs a lock FSM.
- Provides registered phase, lock, error-flag and error-count outputs to the rest of the timing logic.

Parameters:
- N, 4, Johnson word width; 2N legal states; N >= 2.
- LOCK_COUNT, 3, consecutive good advances needed to declare lock; >= 1.
- ERR_LIMIT, 2, consecutive sequence errors while locked that force loss of lock; >= 1.
- PW, $clog2(2*N), phase index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- q_in  in  N  Johnson word from the upstream counter.
- in_valid  in  1  q_in is sampled only when high.
- phase  out  PW  decoded phase index of the last legal sample.
- phase_valid  out  1  one-cycle pulse: phase updated this cycle.
- locked  out  1  FSM is in LOCKED.
- illegal  out  1  one-cycle pulse: sampled word was not a legal Johnson code.
- seq_err  out  1  one-cycle pulse: legal word but neither hold nor +1 successor.
- err_count  out  8  saturating count of illegal and seq_err events since reset.

Behaviour:
- Reset is synchronous and active-high. All outputs go to 0, the FSM goes to HUNT, and the stored previous phase is invalid.
- Reset mid-stream is honoured on the next edge regardless of in_valid. No output pulses are generated in the reset cycle.

Code legality and decode (upstream shifts right, inserting ~q[0] at the MSB):
- Legal word = thermometer pattern: either 1s contiguous from the MSB, or 0s contiguous from the MSB.
- If q[0]==0: phase = number of leading 1s (0..N-1; all-zero gives 0).
- If q[0]==1: phase = N + number of leading 0s (N..2N-1).
- N=4 sequence: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7. After 7 the phase wraps to 0.

Sample classification (only when in_valid=1; all outputs registered, latency 1 cycle):
- Illegal word: illegal=1. phase and prev are held, no phase_valid, counts as an error.
- Legal word with no prev (HUNT): phase loaded, phase_valid=1, prev set, FSM goes to ACQ with good=0.
- Legal word equal to prev: HOLD. phase_valid=1, phase unchanged. Not an error and not a good advance; good and bad counters untouched.
  - This tolerates the repeated zeros the pipelined counter emits after its reset.
- Legal word equal to (prev+1) mod 2N: GOOD. The 2N-1 to 0 wrap is good.
- Any other legal word: seq_err=1. phase and prev are updated to the new value (re-anchor), and it counts as an error.
- in_valid=0: no state change and no pulses.

FSM:
- HUNT: on the first legal sample, go to ACQ. Illegal samples stay in HUNT.
- ACQ: each GOOD increments good. When good reaches LOCK_COUNT, go to LOCKED. Any error resets good to 0 and stays in ACQ.
- LOCKED: locked=1. Each error increments bad; GOOD clears bad; HOLD leaves bad unchanged. When bad reaches ERR_LIMIT, go to HUNT, clear prev-valid, and set locked=0 on the same edge.

Counter and width rules:
- err_count saturates at 255.
- illegal and seq_err are mutually exclusive.
- good and bad counter widths come from $clog2(LIMIT+1).

Optional Feature:
- Macro JOHNSON_DEC_STICKY_ERR_EN.
- Defined: adds input err_clr (1 bit) and output err_sticky (1 bit).
  - err_sticky sets on any illegal or seq_err and holds until err_clr or reset.
  - If err_clr and an error occur in the same cycle, set wins.
  - err_clr also zeroes err_count.
- Undefined: neither port exists; err_count only clears on reset.

Decomposition:
- Package johnson_pkg holds:
  - the FSM state enum (HUNT, ACQ, LOCKED);
  - the sample-class enum (NONE, HOLD, GOOD, SEQ, ILL);
  - the err_count width constant;
  - a function computing the phase width from N.
- One natural sub-module: johnson_code_check. It is purely combinational, maps q_in to {legal, phase}, and is reusable by other Johnson consumers.
- The top level holds prev, the FSM, the counters and the output registers.

Test Plan:
- Reset, then feed 0000 ×3, then 1000, 1100, 1110, 1111 each with valid -> phase 0 then 1,2,3,4. locked rises the cycle after 1110 (third GOOD); no error pulses.
- Locked at phase 7 (0001), next 0000 -> treated as GOOD wrap, phase=0, locked stays 1, err_count=0.
- Locked, inject 1010 -> illegal=1 for one cycle, phase held, err_count=1. A second illegal sample (ERR_LIMIT=2) -> locked falls and FSM returns to HUNT.
- Locked at phase 2, inject 1111 (phase 4) -> seq_err=1, phase=4 (re-anchor); next 0111 is GOOD and bad clears, so locked stays 1.
- Toggle in_valid low for 5 cycles while q_in changes -> no output changes. Assert reset mid-ACQ -> all outputs 0 next edge and FSM in HUNT.
- With JOHNSON_DEC_STICKY_ERR_EN: inject an illegal word -> err_sticky=1. Pulse err_clr together with a seq_err -> err_sticky stays 1. err_clr alone -> err_sticky=0, err_count=0.
